// File: rtl/axil_pkg.sv
// Shared AXI4-Lite response codes and bridge FSM state encoding.
package axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } axil_mst_state_t;

endpackage

// File: rtl/axil_master_if.sv
// AXI4-Lite five-channel bundle between the command bridge (master) and a slave.
interface axil_master_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   awaddr;
    logic                    awvalid;
    logic                    awready;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    wvalid;
    logic                    wready;
    logic [1:0]              bresp;
    logic                    bvalid;
    logic                    bready;
    logic [ADDR_WIDTH-1:0]   araddr;
    logic                    arvalid;
    logic                    arready;
    logic [DATA_WIDTH-1:0]   rdata;
    logic [1:0]              rresp;
    logic                    rvalid;
    logic                    rready;

    modport master (
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_master.sv
// Single-outstanding command to AXI4-Lite bridge with registered AXI and response outputs.
// Optional misaligned-address rejection is enabled by defining AXIL_MASTER_ALIGN_CHK_EN.
module axil_master
    import axil_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_we,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic [1:0]              rsp_resp,
    axil_master_if.master           axi
);

    axil_mst_state_t state_q, state_d;
    logic aw_done_q, aw_done_d, w_done_q, w_done_d;
    logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, arvalid_q, arvalid_d;
    logic bready_q, bready_d, rready_q, rready_d;
    logic rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d;
    logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic [1:0]              rsp_resp_q, rsp_resp_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [DATA_WIDTH/8-1:0] wstrb_q, wstrb_d;
    logic                    we_q, we_d;

    logic cmd_hs, aw_hs, w_hs, b_hs, ar_hs, r_hs, misaligned;

    assign cmd_ready = (state_q == IDLE) && !rst;
    assign cmd_hs    = cmd_valid && cmd_ready;
    assign aw_hs     = awvalid_q && axi.awready;
    assign w_hs      = wvalid_q && axi.wready;
    assign b_hs      = bready_q && axi.bvalid;
    assign ar_hs     = arvalid_q && axi.arready;
    assign r_hs      = rready_q && axi.rvalid;

`ifdef AXIL_MASTER_ALIGN_CHK_EN
    localparam int STRB_W = DATA_WIDTH / 8;
    assign misaligned = (cmd_addr & ADDR_WIDTH'(STRB_W - 1)) != '0;
`else
    assign misaligned = 1'b0;
`endif

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case infers a latch.
        state_d     = state_q;
        aw_done_d   = aw_done_q;
        w_done_d    = w_done_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        arvalid_d   = arvalid_q;
        bready_d    = bready_q;
        rready_d    = rready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_we_d    = rsp_we_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        we_d        = we_q;

        unique case (state_q)
            IDLE: if (cmd_hs) begin
                addr_d  = cmd_addr;
                wdata_d = cmd_wdata;
                wstrb_d = cmd_wstrb;
                we_d    = cmd_we;
                if (misaligned) begin
                    state_d     = RSP;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = cmd_we;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = RESP_SLVERR;
                end else if (cmd_we) begin
                    state_d   = WR_REQ;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    state_d   = RD_REQ;
                    arvalid_d = 1'b1;
                end
            end
            WR_REQ: begin
                // AW and W retire independently; B is awaited once both have landed.
                if (aw_hs) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_hs) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if (aw_done_d && w_done_d) begin
                    state_d  = WR_RESP;
                    bready_d = 1'b1;
                end
            end
            WR_RESP: if (b_hs) begin
                bready_d    = 1'b0;
                rsp_resp_d  = axi.bresp;
                rsp_rdata_d = '0;
                rsp_we_d    = we_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RD_REQ: if (ar_hs) begin
                arvalid_d = 1'b0;
                rready_d  = 1'b1;
                state_d   = RD_RESP;
            end
            RD_RESP: if (r_hs) begin
                rready_d    = 1'b0;
                rsp_rdata_d = axi.rdata;
                rsp_resp_d  = axi.rresp;
                rsp_we_d    = we_q;
                rsp_valid_d = 1'b1;
                state_d     = RSP;
            end
            RSP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            aw_done_q   <= 1'b0;
            w_done_q    <= 1'b0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            bready_q    <= 1'b0;
            rready_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= RESP_OKAY;
        end else begin
            state_q     <= state_d;
            aw_done_q   <= aw_done_d;
            w_done_q    <= w_done_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            arvalid_q   <= arvalid_d;
            bready_q    <= bready_d;
            rready_q    <= rready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
        end
    end

    // NOTE: the command capture registers carry no reset; they are only observed while a valid they qualify is high.
    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
        we_q    <= we_d;
    end

    assign axi.awaddr  = addr_q;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = wdata_q;
    assign axi.wstrb   = wstrb_q;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;
    assign axi.araddr  = addr_q;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axil_master.sv
// Directed bench for axil_master against a small AXI-Lite memory slave with tunable ready/latency.
module tb_axil_master;
    import axil_pkg::*;

    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic          cmd_valid = 1'b0;
    logic          cmd_we    = 1'b0;
    logic [AW-1:0] cmd_addr  = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic [3:0]    cmd_wstrb = '0;
    logic          cmd_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic          rsp_we;
    logic [DW-1:0] rsp_rdata;
    logic [1:0]    rsp_resp;

    axil_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) axi();

    axil_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_we    (cmd_we),
        .cmd_addr  (cmd_addr),
        .cmd_wdata (cmd_wdata),
        .cmd_wstrb (cmd_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_we    (rsp_we),
        .rsp_rdata (rsp_rdata),
        .rsp_resp  (rsp_resp),
        .axi       (axi)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Slave model: word memory, per-channel ready delay, programmable response codes.
    int         aw_delay = 0, w_delay = 0, ar_delay = 0, r_delay = 0;
    logic [1:0] b_code = RESP_OKAY, r_code = RESP_OKAY;
    int         aw_wait, w_wait, ar_wait, r_cnt;
    logic       aw_got, w_got, r_pend;
    logic [7:0] s_awaddr, s_araddr;
    logic [31:0] s_wdata;
    logic [3:0] s_wstrb;
    logic [31:0] mem [64];

    assign axi.awready = axi.awvalid && (aw_wait >= aw_delay);
    assign axi.wready  = axi.wvalid && (w_wait >= w_delay);
    assign axi.arready = axi.arvalid && (ar_wait >= ar_delay);

    always @(posedge clk) begin
        if (rst) begin
            aw_wait <= 0; w_wait <= 0; ar_wait <= 0; r_cnt <= 0;
            aw_got <= 1'b0; w_got <= 1'b0; r_pend <= 1'b0;
            axi.bvalid <= 1'b0; axi.bresp <= 2'b00;
            axi.rvalid <= 1'b0; axi.rresp <= 2'b00; axi.rdata <= '0;
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else begin
            if (axi.awvalid && !axi.awready) aw_wait <= aw_wait + 1;
            if (axi.awvalid && axi.awready) begin
                aw_wait <= 0; aw_got <= 1'b1; s_awaddr <= axi.awaddr;
            end
            if (axi.wvalid && !axi.wready) w_wait <= w_wait + 1;
            if (axi.wvalid && axi.wready) begin
                w_wait <= 0; w_got <= 1'b1; s_wdata <= axi.wdata; s_wstrb <= axi.wstrb;
            end
            if (aw_got && w_got && !axi.bvalid) begin
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) mem[s_awaddr[7:2]][8*b +: 8] <= s_wdata[8*b +: 8];
                axi.bvalid <= 1'b1; axi.bresp <= b_code;
                aw_got <= 1'b0; w_got <= 1'b0;
            end
            if (axi.bvalid && axi.bready) axi.bvalid <= 1'b0;

            if (axi.arvalid && !axi.arready) ar_wait <= ar_wait + 1;
            if (axi.arvalid && axi.arready) begin
                ar_wait <= 0; r_pend <= 1'b1; r_cnt <= 0; s_araddr <= axi.araddr;
            end
            if (r_pend && !axi.rvalid) begin
                if (r_cnt >= r_delay) begin
                    axi.rvalid <= 1'b1; axi.rdata <= mem[s_araddr[7:2]];
                    axi.rresp <= r_code; r_pend <= 1'b0;
                end else begin
                    r_cnt <= r_cnt + 1;
                end
            end
            if (axi.rvalid && axi.rready) axi.rvalid <= 1'b0;
        end
    end

    // Returns at the first falling edge after the command handshake edge.
    task automatic issue(input logic we, input logic [7:0] addr, input logic [31:0] data,
                         input logic [3:0] strb);
        int n = 0;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data; cmd_wstrb = strb;
        while (!cmd_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("cmd_accept", cmd_ready, 1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output logic we, output logic [31:0] rdata, output logic [1:0] resp);
        int n = 0;
        while (!rsp_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("rsp_arrive", rsp_valid, 1);
        we = rsp_we; rdata = rsp_rdata; resp = rsp_resp;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic        we_o;
        logic [31:0] rd_o, hold_rd;
        logic [1:0]  rs_o, hold_rs;
        int          n;

        repeat (2) @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 0);
        check("rst_awvalid", axi.awvalid, 0);
        check("rst_wvalid", axi.wvalid, 0);
        check("rst_arvalid", axi.arvalid, 0);
        check("rst_bready", axi.bready, 0);
        check("rst_rready", axi.rready, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_fields", {rsp_we, rsp_resp, rsp_rdata[28:0]}, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_cmd_ready", cmd_ready, 1);

        // Write then read back the same word.
        issue(1'b1, 8'h10, 32'hDEADBEEF, 4'hF);
        check("wr_awvalid", axi.awvalid, 1);
        check("wr_wvalid", axi.wvalid, 1);
        check("wr_awaddr", axi.awaddr, 32'h10);
        check("wr_wdata", axi.wdata, 32'hDEADBEEF);
        check("wr_wstrb", axi.wstrb, 32'hF);
        wait_rsp(we_o, rd_o, rs_o);
        check("wr_rsp_resp", rs_o, 0);
        check("wr_rsp_we", we_o, 1);
        check("wr_rsp_rdata", rd_o, 0);

        issue(1'b0, 8'h10, 32'h0, 4'h0);
        check("rd_arvalid", axi.arvalid, 1);
        check("rd_araddr", axi.araddr, 32'h10);
        wait_rsp(we_o, rd_o, rs_o);
        check("rd_rsp_rdata", rd_o, 32'hDEADBEEF);
        check("rd_rsp_resp", rs_o, 0);
        check("rd_rsp_we", we_o, 0);

        // Partial strobe over an all-ones word.
        issue(1'b1, 8'h20, 32'hFFFFFFFF, 4'hF);
        wait_rsp(we_o, rd_o, rs_o);
        issue(1'b1, 8'h20, 32'h11223344, 4'h3);
        wait_rsp(we_o, rd_o, rs_o);
        issue(1'b0, 8'h20, 32'h0, 4'h0);
        wait_rsp(we_o, rd_o, rs_o);
        check("strb_rdata", rd_o, 32'hFFFF3344);

        // AW held off three cycles, W immediate, slave returns SLVERR.
        aw_delay = 3;
        b_code   = RESP_SLVERR;
        issue(1'b1, 8'h30, 32'h12345678, 4'hF);
        check("skew_n1_aw", axi.awvalid, 1);
        check("skew_n1_w", axi.wvalid, 1);
        for (int i = 2; i <= 4; i++) begin
            @(negedge clk);
            check($sformatf("skew_n%0d_aw", i), axi.awvalid, 1);
            check($sformatf("skew_n%0d_awaddr", i), axi.awaddr, 32'h30);
            check($sformatf("skew_n%0d_w", i), axi.wvalid, 0);
            check($sformatf("skew_n%0d_bready", i), axi.bready, 0);
        end
        @(negedge clk);
        check("skew_n5_aw", axi.awvalid, 0);
        check("skew_n5_bready", axi.bready, 1);
        wait_rsp(we_o, rd_o, rs_o);
        check("skew_rsp_resp", rs_o, 32'h2);
        aw_delay = 0;
        b_code   = RESP_OKAY;

        // Response backpressure with a DECERR read response.
        r_code = RESP_DECERR;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        n = 0;
        while (!rsp_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_rsp_valid", rsp_valid, 1);
        hold_rd = rsp_rdata;
        hold_rs = rsp_resp;
        check("bp_rdata", hold_rd, 32'hDEADBEEF);
        check("bp_resp", hold_rs, 32'h3);
        cmd_valid = 1'b1; cmd_we = 1'b1; cmd_addr = 8'h44;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_valid", rsp_valid, 1);
            check("bp_hold_rdata", rsp_rdata, 32'hDEADBEEF);
            check("bp_hold_resp", rsp_resp, 32'h3);
            check("bp_hold_cmd_ready", cmd_ready, 0);
            check("bp_no_awvalid", axi.awvalid, 0);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check("bp_after_valid", rsp_valid, 0);
        check("bp_after_cmd_ready", cmd_ready, 1);
        r_code = RESP_OKAY;

        // Unaligned read address.
        issue(1'b0, 8'h13, 32'h0, 4'h0);
`ifdef AXIL_MASTER_ALIGN_CHK_EN
        check("unal_no_arvalid", axi.arvalid, 0);
        check("unal_rsp_valid", rsp_valid, 1);
        check("unal_rsp_resp_now", rsp_resp, 32'h2);
        wait_rsp(we_o, rd_o, rs_o);
        check("unal_rsp_resp", rs_o, 32'h2);
        check("unal_rsp_rdata", rd_o, 0);
`else
        check("unal_arvalid", axi.arvalid, 1);
        check("unal_araddr", axi.araddr, 32'h13);
        wait_rsp(we_o, rd_o, rs_o);
        check("unal_rsp_rdata", rd_o, 32'hDEADBEEF);
        check("unal_rsp_resp", rs_o, 0);
`endif

        // Reset while waiting on a slow R beat.
        r_delay = 20;
        issue(1'b0, 8'h10, 32'h0, 4'h0);
        n = 0;
        while (!axi.rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("mid_in_rd_resp", axi.rready, 1);
        check("mid_rvalid_low", axi.rvalid, 0);
        rst = 1'b1;
        @(negedge clk);
        check("mid_arvalid", axi.arvalid, 0);
        check("mid_rready", axi.rready, 0);
        check("mid_rsp_valid", rsp_valid, 0);
        check("mid_cmd_ready_in_rst", cmd_ready, 0);
        rst = 1'b0;
        r_delay = 0;
        @(negedge clk);
        check("mid_cmd_ready", cmd_ready, 1);
        issue(1'b1, 8'h40, 32'hA5A5A5A5, 4'hF);
        wait_rsp(we_o, rd_o, rs_o);
        check("post_wr_resp", rs_o, 0);
        check("post_wr_we", we_o, 1);
        issue(1'b0, 8'h40, 32'h0, 4'h0);
        wait_rsp(we_o, rd_o, rs_o);
        check("post_rd_rdata", rd_o, 32'hA5A5A5A5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/axil_master.md
Name: axil_master

Overview:
- Command-to-AXI4-Lite bridge that sits directly upstream of the AXI-Lite memory slave and drives its five channels.
- Accepts one simple read/write command at a time from a local requester.
- Sequences the AW/W/B or AR/R handshakes and returns a single response beat.
- Only one transaction is outstanding at a time. No reordering and no pipelining of commands.

Parameters:
- ADDR_WIDTH, 8, byte-address width of AXI and command address.
- DATA_WIDTH, 32, data width. Must be a multiple of 8 and at least 8.

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  command accepted when both cmd_valid and cmd_ready are high.
- cmd_we  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_WIDTH  byte address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_wstrb  in  DATA_WIDTH/8  write byte strobes.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_we  out  1  echo of cmd_we.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes.
- rsp_resp  out  2  bresp or rresp from the slave.
- awaddr  out  ADDR_WIDTH.  awvalid  out  1.  awready  in  1.
- wdata  out  DATA_WIDTH.  wstrb  out  DATA_WIDTH/8.  wvalid  out  1.  wready  in  1.
- bresp  in  2.  bvalid  in  1.  bready  out  1.
- araddr  out  ADDR_WIDTH.  arvalid  out  1.  arready  in  1.
- rdata  in  DATA_WIDTH.  rresp  in  2.  rvalid  in  1.  rready  out  1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state IDLE. Low: awvalid, wvalid, arvalid, bready, rready, rsp_valid. Zero: rsp_rdata, rsp_resp, rsp_we. cmd_ready is 0 while rst is high.
- All AXI and rsp outputs are registered. cmd_ready = (state == IDLE) && !rst.
- States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
- IDLE:
  - On cmd handshake, latch addr, wdata, wstrb and we.
  - Write: go to WR_REQ and set awvalid = wvalid = 1 in the next cycle, i.e. the cycle after acceptance.
  - Read: go to RD_REQ with arvalid = 1.
- WR_REQ:
  - awvalid and wvalid each deassert independently on their own handshake.
  - Either may complete first, or both in the same cycle.
  - When both have completed (tracked by aw_done and w_done flags), enter WR_RESP with bready = 1.
  - If the last handshake lands this cycle, the transition happens the next cycle.
- WR_RESP: on bvalid && bready, capture bresp into rsp_resp, set rsp_rdata = 0, bready = 0, go to RSP.
- RD_REQ: on arvalid && arready, arvalid = 0, rready = 1, go to RD_RESP.
- RD_RESP: on rvalid && rready, capture rdata and rresp, rready = 0, go to RSP.
- RSP: rsp_valid = 1 and held stable until rsp_ready, then go to IDLE. A new command can be accepted in the cycle after rsp handshake.
- AXI rules:
  - A valid is never dropped before its handshake.
  - Address, data and strobe are stable while valid is high.
  - bready and rready are high only in their wait states.
- Minimum write latency, against a slave with ready already high: accept at N, AW/W handshake at N+1, B at N+2 or later, rsp_valid one cycle after the B handshake.
- rsp_resp passes the slave code through unmodified: 00 OKAY, 10 SLVERR, others as given.
- Reset mid-transaction: the transaction is abandoned and all valids and readies drop in the reset cycle. The slave must be reset in the same cycle, so no late B/R is expected.
- cmd inputs are ignored outside IDLE.

Optional Feature:
- Macro: AXIL_MASTER_ALIGN_CHK_EN.
- Defined:
  - In IDLE, an accepted command with cmd_addr not aligned to DATA_WIDTH/8 issues no AXI traffic.
  - The block goes straight to RSP with rsp_resp = 2'b10 and rsp_rdata = 0, giving rsp_valid in the cycle after acceptance.
- Not defined: all addresses are issued as-is. Alignment is the requester's responsibility.

Decomposition:
- Package axil_pkg holds:
  - the resp constants: RESP_OKAY = 2'b00, RESP_EXOKAY = 2'b01, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - the state enum typedef axil_mst_state_t.
- Single flat module. No sub-module is warranted; the FSM plus the two done-flags is the whole datapath.

Test Plan:
- Write followed by read of the same address:
  - Write cmd addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, slave always ready: awaddr = 0x10 and wdata = 0xDEADBEEF on the cycle after acceptance; rsp_valid with rsp_resp = 00 and rsp_we = 1.
  - Then read 0x10: rsp_rdata = 0xDEADBEEF, rsp_resp = 00.
- Partial strobe: write 0x11223344 to 0x20 with wstrb 0x3 over prior 0xFFFFFFFF, then read 0x20 -> 0xFFFF3344.
- Skewed handshakes: awready delayed 3 cycles, wready immediate -> wvalid drops after 1 cycle, awvalid held 4 cycles with stable awaddr, bready rises only after both handshakes complete.
- Response backpressure: rsp_ready held low 5 cycles -> rsp_valid, rsp_rdata and rsp_resp stable; cmd_ready stays 0 until the cycle after rsp_ready.
- Reset mid-transaction: rst pulsed in RD_RESP while rvalid is low -> next cycle arvalid, rready and rsp_valid are 0 and cmd_ready is 1 after reset releases; a following write completes normally.
- With AXIL_MASTER_ALIGN_CHK_EN defined, read addr 0x13 (DATA_WIDTH 32) -> no arvalid, rsp_resp = 10 one cycle after acceptance.
- Without AXIL_MASTER_ALIGN_CHK_EN, read addr 0x13 -> araddr = 0x13 is issued.
